key_irq_ctrl: RTL and testbench

Avalon-MM slave interrupt controller for the board push-buttons. It sits between the raw key pins and the Nios II interrupt input, alongside the LED PIO in the Qsys system. It synchronises and debounces each key, detects press/release edges per a programmable mode, and latches them in a write-1-to-clear capture register. It raises a level interrupt while any unmasked capture bit is set.

---
 rtl/key_irq_pkg.sv | 25 ++
 rtl/key_debounce.sv | 53 +++++
 rtl/key_irq_ctrl.sv | 111 +++++++++++
 tb/tb_key_irq_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_irq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// key_irq_pkg
//   Shared register offsets and edge-mode encodings for the push-button
//   interrupt controller.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
package key_irq_pkg;

  // Avalon word addresses of the register file
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_ECAP = 2'd2;
  localparam logic [1:0] ADDR_MODE = 2'd3;

  // Which debounced edges are latched into EDGE_CAP
  typedef enum logic [1:0] {
    MODE_PRESS   = 2'b00,
    MODE_RELEASE = 2'b01,
    MODE_BOTH    = 2'b10,
    MODE_NONE    = 2'b11
  } edge_mode_e;

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// key_debounce
//   One key: two-flop synchroniser, inversion to pressed-high, and a
//   stability counter that accepts a new level after DEBOUNCE_CYC cycles.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module key_debounce #(
  parameter int DEBOUNCE_CYC = 2000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic db
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC);

  logic             sync1;
  logic             sync2;
  logic             synced;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser; resets to the released (high) pin level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  assign synced = ~sync2;

  // Accept the synced level only after it has differed from db long enough
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      db  <= 1'b0;
    end else if (synced == db) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
      db  <= synced;
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/key_irq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// key_irq_ctrl
//   Avalon-MM push-button interrupt controller: per-key debounce, edge
//   detection by programmable mode, W1C capture register, masked level irq.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module key_irq_ctrl
  import key_irq_pkg::*;
#(
  parameter int KEY_W        = 4,
  parameter int DEBOUNCE_CYC = 2000000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [KEY_W-1:0]  key,
  input  logic [1:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              irq
);

  logic [KEY_W-1:0] db;
  logic [KEY_W-1:0] db_q;
  logic [KEY_W-1:0] rise;
  logic [KEY_W-1:0] fall;
  logic [KEY_W-1:0] qual;
  logic [KEY_W-1:0] irq_mask;
  logic [KEY_W-1:0] edge_cap;
  logic [KEY_W-1:0] w1c;
  edge_mode_e       edge_mode;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  // Only the low KEY_W (or 2) write bits are meaningful
  assign unused_wdata = ^avs_writedata;

  generate
    for (genvar i = 0; i < KEY_W; i++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
      ) u_debounce (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .key_n (key[i]),
        .db    (db[i])
      );
    end
  endgenerate

  // Previous debounced level for edge detection
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) db_q <= '0;
    else            db_q <= db;
  end

  assign rise = db & ~db_q;
  assign fall = ~db & db_q;

  // Select which edges are captured
  always_comb begin
    qual = '0;
    case (edge_mode)
      MODE_PRESS:   qual = rise;
      MODE_RELEASE: qual = fall;
      MODE_BOTH:    qual = rise | fall;
      default:      qual = '0;
    endcase
  end

  assign w1c = (avs_write && avs_address == ADDR_ECAP) ? avs_writedata[KEY_W-1:0] : '0;

  // Register file; a new edge beats a simultaneous W1C on the same bit
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      irq_mask  <= '0;
      edge_cap  <= '0;
      edge_mode <= MODE_PRESS;
    end else begin
      edge_cap <= (edge_cap & ~w1c) | qual;
      if (avs_write && avs_address == ADDR_MASK) irq_mask  <= avs_writedata[KEY_W-1:0];
      if (avs_write && avs_address == ADDR_MODE) edge_mode <= edge_mode_e'(avs_writedata[1:0]);
    end
  end

  // Read mux, zero-extending narrow registers
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_DATA: rd_mux[KEY_W-1:0] = db;
      ADDR_MASK: rd_mux[KEY_W-1:0] = irq_mask;
      ADDR_ECAP: rd_mux[KEY_W-1:0] = edge_cap;
      default:   rd_mux[1:0]       = edge_mode;
    endcase
  end

  // Registered read data held until the next read; registered irq
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      avs_readdata <= '0;
      irq          <= 1'b0;
    end else begin
      if (avs_read) avs_readdata <= rd_mux;
      irq <= |(edge_cap & irq_mask);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_key_irq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_key_irq_ctrl
//   Directed self-checking bench for key_irq_ctrl (KEY_W=4, DEBOUNCE_CYC=16).
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_key_irq_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [3:0]  key = 4'hF;
  logic [1:0]  avs_address = 2'd0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'd0;
  logic [31:0] avs_readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  key_irq_ctrl #(
    .KEY_W        (4),
    .DEBOUNCE_CYC (16)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .key           (key),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .irq           (irq)
  );

  always #5 sys_clk = ~sys_clk;

  // All tasks start and end just after a falling edge
  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    avs_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    avs_address = a;
    avs_read    = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    avs_read    = 1'b0;
    d           = avs_readdata;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    bus_write(2'd1, 32'h0000_000F);
    bus_read(2'd1, rd);
    key = 4'hE;
    wait_cycles(5);
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if (avs_readdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_readdata: got %h expected %h", avs_readdata, 32'd0);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq: got %b expected 0", irq);
    end
    key = 4'hF;
    @(negedge sys_clk);
    wait_cycles(2);
    sys_rst_n = 1'b1;
    wait_cycles(2);
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), rd);
      checks++;
      if (rd !== 32'd0) begin
        errors++;
        $display("FAIL reset_reg%0d: got %h expected %h", a, rd, 32'd0);
      end
    end
  endtask

  task automatic test_debounce();
    logic [31:0] rd;
    key = 4'hE;
    wait_cycles(10);
    key = 4'hF;
    wait_cycles(30);
    bus_read(2'd0, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL glitch_data: got %h expected %h", rd, 32'd0);
    end
    bus_read(2'd2, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL glitch_ecap: got %h expected %h", rd, 32'd0);
    end
    // Real press: db must change on the 18th edge after the pin falls
    key         = 4'hE;
    avs_address = 2'd0;
    avs_read    = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      if (i == 18) begin
        checks++;
        if (avs_readdata !== 32'd0) begin
          errors++;
          $display("FAIL debounce_early: got %h expected %h", avs_readdata, 32'd0);
        end
      end
      if (i == 19) begin
        checks++;
        if (avs_readdata !== 32'd1) begin
          errors++;
          $display("FAIL debounce_latency: got %h expected %h", avs_readdata, 32'd1);
        end
      end
    end
    avs_read = 1'b0;
    key = 4'hF;
    wait_cycles(25);
    bus_write(2'd2, 32'h0000_000F);
    wait_cycles(2);
  endtask

  task automatic test_press_irq();
    logic [31:0] rd;
    bus_write(2'd1, 32'hFFFF_FFF1);
    bus_write(2'd3, 32'd0);
    bus_read(2'd1, rd);
    checks++;
    if (rd !== 32'h0000_0001) begin
      errors++;
      $display("FAIL mask_unused_bits: got %h expected %h", rd, 32'h1);
    end
    key = 4'hE;
    for (int i = 1; i <= 20; i++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      if (i == 19) begin
        checks++;
        if (irq !== 1'b0) begin
          errors++;
          $display("FAIL press_irq_early: got %b expected 0", irq);
        end
      end
      if (i == 20) begin
        checks++;
        if (irq !== 1'b1) begin
          errors++;
          $display("FAIL press_irq: got %b expected 1", irq);
        end
      end
    end
    bus_read(2'd2, rd);
    checks++;
    if (rd !== 32'h1) begin
      errors++;
      $display("FAIL press_ecap: got %h expected %h", rd, 32'h1);
    end
    // W1C: irq drops two edges after the strobe
    avs_address   = 2'd2;
    avs_writedata = 32'h1;
    avs_write     = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    avs_write = 1'b0;
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL w1c_irq_hold: got %b expected 1", irq);
    end
    @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL w1c_irq_drop: got %b expected 0", irq);
    end
    key = 4'hF;
    wait_cycles(25);
    bus_read(2'd2, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL press_release_ignored: got %h expected %h", rd, 32'h0);
    end
  endtask

  task automatic test_mask_mode();
    logic [31:0] rd;
    bus_write(2'd1, 32'h0);
    bus_write(2'd3, 32'h1);
    key = 4'hB;
    wait_cycles(25);
    bus_read(2'd2, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL release_mode_press: got %h expected %h", rd, 32'h0);
    end
    key = 4'hF;
    wait_cycles(25);
    bus_read(2'd2, rd);
    checks++;
    if (rd !== 32'h4) begin
      errors++;
      $display("FAIL release_mode_cap: got %h expected %h", rd, 32'h4);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL masked_irq: got %b expected 0", irq);
    end
    bus_write(2'd1, 32'h4);
    wait_cycles(1);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL unmask_irq: got %b expected 1", irq);
    end
    bus_write(2'd2, 32'h4);
    wait_cycles(2);
  endtask

  task automatic test_collision();
    logic [31:0] rd;
    bus_write(2'd3, 32'h0);
    bus_write(2'd1, 32'h2);
    key = 4'hD;
    wait_cycles(18);
    // W1C lands on the same edge that captures the key[1] press
    avs_address   = 2'd2;
    avs_writedata = 32'h2;
    avs_write     = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    avs_write = 1'b0;
    wait_cycles(3);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL collision_irq: got %b expected 1", irq);
    end
    bus_read(2'd2, rd);
    checks++;
    if (rd !== 32'h2) begin
      errors++;
      $display("FAIL collision_ecap: got %h expected %h", rd, 32'h2);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_rd [4];
    bus_write(2'd2, 32'h2);
    bus_write(2'd3, 32'h3);
    bus_write(2'd1, 32'hD);
    exp_rd[0] = 32'h2;
    exp_rd[1] = 32'hD;
    exp_rd[2] = 32'h0;
    exp_rd[3] = 32'h3;
    avs_read = 1'b1;
    for (int a = 0; a < 4; a++) begin
      avs_address = 2'(a);
      @(posedge sys_clk);
      @(negedge sys_clk);
      checks++;
      if (avs_readdata !== exp_rd[a]) begin
        errors++;
        $display("FAIL b2b_read%0d: got %h expected %h", a, avs_readdata, exp_rd[a]);
      end
    end
    avs_read    = 1'b0;
    avs_address = 2'd0;
    wait_cycles(1);
    checks++;
    if (avs_readdata !== 32'h3) begin
      errors++;
      $display("FAIL readdata_hold: got %h expected %h", avs_readdata, 32'h3);
    end
  endtask

  task automatic test_read_write_same();
    logic [31:0] rd;
    avs_address   = 2'd1;
    avs_writedata = 32'h6;
    avs_write     = 1'b1;
    avs_read      = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    avs_write = 1'b0;
    avs_read  = 1'b0;
    checks++;
    if (avs_readdata !== 32'hD) begin
      errors++;
      $display("FAIL rw_same_old: got %h expected %h", avs_readdata, 32'hD);
    end
    bus_read(2'd1, rd);
    checks++;
    if (rd !== 32'h6) begin
      errors++;
      $display("FAIL rw_same_new: got %h expected %h", rd, 32'h6);
    end
    bus_write(2'd0, 32'hF);
    bus_read(2'd0, rd);
    checks++;
    if (rd !== 32'h2) begin
      errors++;
      $display("FAIL data_readonly: got %h expected %h", rd, 32'h2);
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    wait_cycles(2);
    test_reset();
    test_debounce();
    test_press_irq();
    test_mask_mode();
    test_collision();
    test_back_to_back();
    test_read_write_same();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
